// File: rtl/spi_controller.sv
// SPI mode-0 master: one WORD_SIZE word per start, MSB first, CLK_DIV clk_i cycles per sck half-period.
// Define SPI_CONTROLLER_BURST_EN to chain words under one continuous chip select.
module spi_controller #(
    parameter int WORD_SIZE = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WORD_SIZE-1:0] data_tx_i,
    output logic [WORD_SIZE-1:0] data_rx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sck_o,
    output logic                 cs_o,
    output logic                 sdo_o,
    input  logic                 sdi_i,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * WORD_SIZE);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WORD_SIZE - 1);
    localparam logic [HALF_W-1:0] FALL_LAST = HALF_W'(2 * WORD_SIZE - 2);

    state_t                state, state_n;
    logic [DIV_W-1:0]      div_cnt, div_n;
    logic [HALF_W-1:0]     half_cnt, half_n;
    logic [WORD_SIZE-1:0]  tx_sr, tx_n;
    logic [WORD_SIZE-1:0]  rx_sr, rx_n;
    logic [WORD_SIZE-1:0]  data_rx_q;
    logic                  div_end;
    logic                  rx_load;

    assign div_end = (div_cnt == DIV_LAST);

    // start_i is a one-cycle request, accepted only in IDLE (or in the done_o cycle when bursting);
    // busy_o rises the cycle after acceptance and done_o marks the final cycle of the word.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        half_n  = half_cnt;
        tx_n    = tx_sr;
        rx_n    = rx_sr;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = SETUP;
                    tx_n    = data_tx_i;
                    rx_n    = '0;
                    div_n   = '0;
                    half_n  = '0;
                end
            end
            SETUP: begin
                if (div_end) begin
                    // Entering SHIFT raises sck, so this edge is also the first sample point.
                    state_n = SHIFT;
                    div_n   = '0;
                    half_n  = '0;
                    rx_n    = {rx_sr[WORD_SIZE-2:0], sdi_i};
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_n = '0;
                    if (half_cnt == HALF_LAST) begin
                        state_n = HOLD;
                    end else begin
                        half_n = half_cnt + HALF_W'(1);
                        if (half_cnt[0]) begin
                            rx_n = {rx_sr[WORD_SIZE-2:0], sdi_i};
                        end else if (half_cnt != FALL_LAST) begin
                            tx_n = {tx_sr[WORD_SIZE-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_n   = '0;
                    half_n  = '0;
                    state_n = IDLE;
`ifdef SPI_CONTROLLER_BURST_EN
                    if (start_i) begin
                        state_n = SETUP;
                        tx_n    = data_tx_i;
                        rx_n    = '0;
                    end
`endif
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The received word is published on the edge that opens the done_o cycle.
    assign rx_load = (state_n == HOLD) && (div_n == DIV_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            div_cnt   <= '0;
            half_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            data_rx_q <= '0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            half_cnt <= half_n;
            tx_sr    <= tx_n;
            rx_sr    <= rx_n;
            if (rx_load) begin
                data_rx_q <= rx_sr;
            end
        end
    end

    assign busy_o    = (state != IDLE);
    assign cs_o      = (state == IDLE);
    assign sck_o     = (state == SHIFT) && !half_cnt[0];
    assign sdo_o     = (state != IDLE) && tx_sr[WORD_SIZE-1];
    assign done_o    = (state == HOLD) && div_end;
    assign data_rx_o = data_rx_q;
    assign state_o   = state;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a mode-0 peripheral model feeds sdi, a scoreboard checks sdo bits,
// received words and done_o timing; a second CLK_DIV=1 instance covers the fastest divider.
module tb_spi_controller;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int T  = (2 * W + 2) * D;
    localparam int T1 = (2 * W + 2) * 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         start_a = 1'b0;
    logic [W-1:0] data_tx_a = '0;
    logic [W-1:0] data_rx_a;
    logic         busy_a, done_a, sck_a, cs_a, sdo_a, sdi_a;
    logic [1:0]   state_a;

    logic         start_b = 1'b0;
    logic [W-1:0] data_tx_b = '0;
    logic [W-1:0] data_rx_b;
    logic         busy_b, done_b, sck_b, cs_b, sdo_b;
    logic         sdi_b = 1'b0;
    logic [1:0]   state_b;

    spi_controller #(.WORD_SIZE(W), .CLK_DIV(D)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .data_tx_i(data_tx_a),
        .data_rx_o(data_rx_a), .busy_o(busy_a), .done_o(done_a), .sck_o(sck_a),
        .cs_o(cs_a), .sdo_o(sdo_a), .sdi_i(sdi_a), .state_o(state_a)
    );

    spi_controller #(.WORD_SIZE(W), .CLK_DIV(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .data_tx_i(data_tx_b),
        .data_rx_o(data_rx_b), .busy_o(busy_b), .done_o(done_b), .sck_o(sck_b),
        .cs_o(cs_b), .sdo_o(sdo_b), .sdi_i(sdi_b), .state_o(state_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: presents word bits MSB first, advancing one bit per sck falling edge.
    logic [W-1:0] p_word0 = '0;
    logic [W-1:0] p_word1 = '0;
    int           p_idx = 0;

    function automatic logic periph_bit(int idx, logic [W-1:0] w0, logic [W-1:0] w1);
        logic [W-1:0] w;
        w = (idx < W) ? w0 : w1;
        return w[W - 1 - (idx % W)];
    endfunction

    assign sdi_a = periph_bit(p_idx, p_word0, p_word1);
    always @(negedge sck_a) p_idx = p_idx + 1;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];
    logic         exp_bit_q[$];
    logic [W-1:0] exp_b_q[$];
    int           exp_tb_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int rises = 0;
    int done_count = 0;
    int prev_done_cyc = 0;
    int last_done_cyc = 0;
    int done_b_count = 0;
    logic prev_sck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor for the CLK_DIV=2 instance
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sck_a === 1'b1 && prev_sck === 1'b0) begin
                rises++;
                if (exp_bit_q.size() == 0) check("sdo_unexpected_rise", sck_a, 0);
                else check("sdo_bit", sdo_a, exp_bit_q.pop_front());
            end
            prev_sck = sck_a;
            if (done_a === 1'b1) begin
                done_count++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) check("done_unexpected", done_a, 0);
                else begin
                    check("data_rx", data_rx_a, exp_q.pop_front());
                    check("done_cycle", cyc, exp_t_q.pop_front());
                end
            end
        end
    end

    // Monitor for the CLK_DIV=1 instance
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (done_b === 1'b1) begin
                done_b_count++;
                if (exp_b_q.size() == 0) check("b_done_unexpected", done_b, 0);
                else begin
                    check("b_data_rx", data_rx_b, exp_b_q.pop_front());
                    check("b_done_cycle", cyc, exp_tb_q.pop_front());
                end
            end
        end
    end

    task automatic flush();
        exp_q.delete();
        exp_t_q.delete();
        exp_bit_q.delete();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        flush();
        p_idx = 0;
    endtask

    // done_o occupies cycle T counting the first cycle after the accepting edge as cycle 1.
    task automatic push_word(input logic [W-1:0] tx, input logic [W-1:0] rx, input int acc);
        for (int i = W - 1; i >= 0; i--) exp_bit_q.push_back(tx[i]);
        exp_q.push_back(rx);
        exp_t_q.push_back(acc + T - 1);
    endtask

    task automatic send_word(input logic [W-1:0] tx, input logic [W-1:0] rx, output int acc);
        @(negedge clk);
        p_word0 = rx;
        p_idx = 0;
        start_a = 1'b1;
        data_tx_a = tx;
        acc = cyc + 1;
        push_word(tx, rx, acc);
        @(negedge clk);
        start_a = 1'b0;
        data_tx_a = W'($urandom);
    endtask

    task automatic wait_until(input int target);
        int k;
        k = 0;
        while (cyc < target && k < 500) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy_a !== 1'b0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int acc, d0, r0, cs_high, k, acc1, acc2, errs, accb;
        logic [W-1:0] tx, rx;

        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, d0, r0, cs_high, k, acc1, acc2, errs, accb, db0;
        logic [W-1:0] tx, rx;

        // Reset
        do_reset(2);
        check("rst_cs", cs_a, 1);
        check("rst_sck", sck_a, 0);
        check("rst_sdo", sdo_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_data_rx", data_rx_a, 0);
        check("rst_b_cs", cs_b, 1);
        check("rst_b_data_rx", data_rx_b, 0);

        // Single word
        d0 = done_count;
        send_word(8'hA5, 8'h3C, acc);
        check("busy_after_accept", busy_a, 1);
        check("cs_after_accept", cs_a, 0);
        wait_until(acc + T - 1);
        check("done_at_final_cycle", done_a, 1);
        @(negedge clk);
        check("busy_low_after_done", busy_a, 0);
        check("done_single_pulse", done_a, 0);
        check("cs_high_after_done", cs_a, 1);
        check("single_done_count", done_count - d0, 1);
        repeat (5) @(negedge clk);
        check("data_rx_held", data_rx_a, 8'h3C);

        // Start while busy
        d0 = done_count;
        send_word(8'hA5, 8'h96, acc);
        wait_until(acc + 9);
        start_a = 1'b1;
        data_tx_a = 8'hFF;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle("busy_start_drain");
        repeat (4) @(negedge clk);
        check("busy_start_one_done", done_count - d0, 1);

        // Reset mid-transfer
        d0 = done_count;
        send_word(8'hC3, 8'h5A, acc);
        wait_until(acc + 14);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush();
        check("midrst_cs", cs_a, 1);
        check("midrst_sck", sck_a, 0);
        check("midrst_sdo", sdo_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_data_rx", data_rx_a, 0);
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_count - d0, 0);
        send_word(8'h81, 8'hE7, acc);
        wait_idle("after_rst_drain");

        // Randomised words
        for (int n = 0; n < 8; n++) begin
            tx = W'($urandom);
            rx = W'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_word(tx, rx, acc);
            wait_idle("random_drain");
        end

        // Start held for two words
        @(negedge clk);
        p_word0 = 8'h9C;
        p_word1 = 8'h47;
        p_idx = 0;
        r0 = rises;
        d0 = done_count;
        start_a = 1'b1;
        data_tx_a = 8'h12;
        acc1 = cyc + 1;
`ifdef SPI_CONTROLLER_BURST_EN
        acc2 = acc1 + T;
`else
        acc2 = acc1 + T + 1;
`endif
        push_word(8'h12, 8'h9C, acc1);
        push_word(8'h34, 8'h47, acc2);
        @(negedge clk);
        data_tx_a = 8'h34;
        cs_high = 0;
        k = 0;
        while (cyc < acc2 && k < 500) begin
            if (cs_a === 1'b1) cs_high++;
            @(negedge clk);
            k++;
        end
        start_a = 1'b0;
        wait_idle("burst_drain");
        check("burst_rises", rises - r0, 2 * W);
        check("burst_done_count", done_count - d0, 2);
        check("burst_done_spacing", last_done_cyc - prev_done_cyc, acc2 - acc1);
`ifdef SPI_CONTROLLER_BURST_EN
        check("burst_cs_low", cs_high, 0);
`else
        check("burst_cs_gap", (cs_high >= 1), 1);
`endif

        // CLK_DIV=1 instance
        db0 = done_b_count;
        @(negedge clk);
        start_b = 1'b1;
        data_tx_b = 8'hFF;
        accb = cyc + 1;
        exp_b_q.push_back(8'h00);
        exp_tb_q.push_back(accb + T1 - 1);
        @(negedge clk);
        start_b = 1'b0;
        errs = 0;
        for (int c = 1; c <= T1 + 2; c++) begin
            if (c >= 2 && c <= T1 - 1) begin
                if (sck_b !== ((c % 2) == 0)) errs++;
                if (sck_b === 1'b1 && sdo_b !== 1'b1) errs++;
            end else if (sck_b !== 1'b0) errs++;
            if (c == T1) check("b_done_at_final_cycle", done_b, 1);
            @(negedge clk);
        end
        check("b_sck_pattern", errs, 0);
        check("b_done_count", done_b_count - db0, 1);
        check("b_busy_idle", busy_b, 0);
        check("b_queue_drained", exp_b_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter WORD_SIZE, default 8: bits per word, at least 2.
REQ-002 Parameter CLK_DIV, default 2: clk_i cycles per sck half-period, at least 1.
REQ-003 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request a word transfer; sampled on each clk_i rising edge.
REQ-006 data_tx_i  input  WORD_SIZE  word to send, MSB first; captured when start is accepted.
REQ-007 data_rx_o  output  WORD_SIZE  last complete received word.
REQ-008 busy_o  output  1  high from start acceptance until the transfer ends.
REQ-009 done_o  output  1  one-cycle pulse marking the final cycle of a word.
REQ-010 sck_o  output  1  serial clock, idle low (mode 0).
REQ-011 cs_o  output  1  chip select, active-low, idle high.
REQ-012 sdo_o  output  1  serial data to the peripheral.
REQ-013 sdi_i  input  1  serial data from the peripheral.

Function
REQ-014 The FSM SHALL have four states: IDLE, SETUP, SHIFT and HOLD.
REQ-015 IDLE SHALL drive cs_o=1, sck_o=0, sdo_o=0, busy_o=0 and done_o=0.
REQ-016 IDLE with start_i=1 SHALL capture data_tx_i, go to SETUP and set busy_o=1 from the next cycle.
REQ-017 SETUP SHALL last CLK_DIV cycles with cs_o=0, sck_o=0 and sdo_o=tx MSB.
REQ-018 SHIFT SHALL toggle sck_o every CLK_DIV cycles, starting high, for WORD_SIZE full sck periods; 2*WORD_SIZE*CLK_DIV cycles in total.
REQ-019 On each sck_o rising transition, the block SHALL shift sdi_i into the rx shift register LSB.
REQ-020 On each sck_o falling transition except the last, the block SHALL shift the tx register left and present the next bit on sdo_o.
REQ-021 After the last falling transition, the FSM SHALL enter HOLD, which lasts CLK_DIV cycles with sck_o=0 and cs_o=0.
REQ-022 In the last HOLD cycle, done_o SHALL be 1 and data_rx_o SHALL update at the same edge.
REQ-023 done_o SHALL therefore be high exactly (2*WORD_SIZE+2)*CLK_DIV cycles after the start-accept edge.
REQ-024 After HOLD, the FSM SHALL return to IDLE unless REQ-031 applies.
REQ-025 start_i SHALL be ignored in SETUP, in SHIFT, and in HOLD cycles other than the last.
REQ-026 data_tx_i changes after capture SHALL not affect the word in flight.
REQ-027 data_rx_o SHALL hold its value between done_o pulses.

Reset
REQ-028 rst_i=1 SHALL, at the next clk_i edge from any state (mid-transfer included), force IDLE outputs and data_rx_o=0, with no done_o pulse.
REQ-029 On reset, the shift registers and bit/divider counters SHALL clear to 0.
REQ-030 rst_i SHALL take priority over start_i.

Configuration
REQ-031 SPI_CONTROLLER_BURST_EN defined: start_i=1 in the done_o cycle SHALL capture data_tx_i and go HOLD to SETUP with cs_o held at 0 continuously.
REQ-032 SPI_CONTROLLER_BURST_EN undefined: start_i in the done_o cycle SHALL be ignored, and cs_o SHALL be 1 for at least one IDLE cycle between words.

Verification (WORD_SIZE=8, CLK_DIV=2)
REQ-033 Reset test: rst_i=1 for 2 cycles -> cs_o=1, sck_o=0, sdo_o=0, busy_o=0, done_o=0, data_rx_o=0x00.
REQ-034 Single-word test: start_i pulse with data_tx_i=0xA5, peripheral model returns 0x3C -> sdo_o at the 8 sck rising edges reads 1,0,1,0,0,1,0,1; done_o at cycle 36; data_rx_o=0x3C; busy_o=0 at cycle 37.
REQ-035 Start-while-busy test: second start_i with 0xFF at cycle 10 -> bit sequence unchanged, exactly one done_o pulse.
REQ-036 Reset mid-transfer test: rst_i at cycle 15 -> next cycle cs_o=1, sck_o=0, busy_o=0; no done_o; data_rx_o=0x00; a new 0x81 transfer then completes normally.
REQ-037 Burst test: start_i held with 0x12 then 0x34 -> with macro: cs_o stays low, 16 rising sck edges, 2 done_o pulses 36 cycles apart; without macro: cs_o=1 for at least 1 cycle between words.
REQ-038 CLK_DIV=1 test: 0xFF transfer with sdi_i=0 -> sck_o toggles every cycle, done_o at cycle 18, data_rx_o=0x00.
